uart_tx_fifo: RTL

//  Parametrised UART transmitter, successor of the fixed 8N1 transmitter.
//  - Words are accepted through a valid/ready write port into an internal FIFO.
//  - Frames are serialised LSB-first with runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
//  - Bit timing comes from the shared baud-rate generator tick (i_tick), OVERSAMPLE ticks per bit.
//  - Sits between the host/ALU interface logic and the serial pin.

---
 rtl/uart_tx_fifo.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with TX FIFO, selectable parity and stop bits
module uart_tx_fifo #(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_parity_mode,
    input  logic               i_two_stop,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done_tick,
    output logic               o_fifo_empty
);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int NW  = $clog2(NB_DATA);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int STW = SW + 1;

    localparam logic [SW-1:0]  S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0]  N_LAST  = NW'(NB_DATA - 1);
    localparam logic [STW-1:0] STOP1   = STW'(OVERSAMPLE - 1);
    localparam logic [STW-1:0] STOP2   = STW'(2 * OVERSAMPLE - 1);
    localparam logic [AW:0]    CNT_MAX = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [NB_DATA-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;
    logic               wr_en, pop;

    state_t             state_q, state_d;
    logic [SW-1:0]      s_q, s_d;
    logic [NW-1:0]      n_q, n_d;
    logic [STW-1:0]     stop_q, stop_d;
    logic [NB_DATA-1:0] sh_q, sh_d;
    logic               tx_q, tx_d;
    logic               par_en_q, par_en_d;
    logic               par_bit_q, par_bit_d;
    logic               two_q, two_d;
    logic               done;
    logic [NB_DATA-1:0] head;

    assign o_ready      = (cnt_q != CNT_MAX);
    assign o_fifo_empty = (cnt_q == '0);
    assign wr_en        = i_valid && o_ready;
    assign head         = mem_q[rd_q];

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_q] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (pop)   rd_q <= rd_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            stop_q    <= '0;
            sh_q      <= '0;
            tx_q      <= 1'b1;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            two_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            stop_q    <= stop_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            two_q     <= two_d;
        end
    end

    // tx_d always carries the level of the bit being entered, keeping o_tx a pure register
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        stop_d    = stop_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        two_d     = two_q;
        pop       = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!o_fifo_empty) begin
                    pop       = 1'b1;
                    sh_d      = head;
                    par_en_d  = i_parity_mode[0] ^ i_parity_mode[1];
                    par_bit_d = i_parity_mode[1] ? ~^head : ^head;
                    two_d     = i_two_stop;
                    s_d       = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                        tx_d    = sh_q[0];
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d  = '0;
                        sh_d = sh_q >> 1;
                        if (n_q == N_LAST) begin
                            stop_d = '0;
                            if (par_en_q) begin
                                state_d = PARITY;
                                tx_d    = par_bit_q;
                            end else begin
                                state_d = STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            n_d  = n_q + NW'(1);
                            tx_d = sh_q[1];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        stop_d  = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (i_tick) begin
                    if (stop_q == (two_q ? STOP2 : STOP1)) begin
                        done    = 1'b1;
                        stop_d  = '0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + STW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                s_d     = '0;
                n_d     = '0;
                stop_d  = '0;
            end
        endcase
    end

    assign o_tx           = tx_q;
    assign o_busy         = (state_q != IDLE);
    assign o_tx_done_tick = done;
endmodule
